// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the request/grant handshakes and SDRAM command strobes around the port arbiter.
// The slave modport is the arbiter's view; master is the requester/engine side.
interface sdram_port_arbiter_if #(
  parameter int AddressWidthSDRAM = 24
);
  logic                         wr_req;
  logic [AddressWidthSDRAM-1:0] wr_addr;
  logic                         rd_req;
  logic [AddressWidthSDRAM-1:0] rd_addr;
  logic                         wr_grant;
  logic                         rd_grant;
  logic                         sdram_busy;
  logic                         sdram_done;
  logic                         sdram_enable;
  logic                         sdram_read;
  logic                         sdram_refresh;
  logic [AddressWidthSDRAM-1:0] sdram_addr;
  logic                         refresh_overrun;

  modport slave (
    input  wr_req, wr_addr, rd_req, rd_addr, sdram_busy, sdram_done,
    output wr_grant, rd_grant, sdram_enable, sdram_read, sdram_refresh,
           sdram_addr, refresh_overrun
  );

  modport master (
    output wr_req, wr_addr, rd_req, rd_addr, sdram_busy, sdram_done,
    input  wr_grant, rd_grant, sdram_enable, sdram_read, sdram_refresh,
           sdram_addr, refresh_overrun
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Burst-granular arbiter sharing one SDRAM command engine between a write and a read stream,
// with periodic auto-refresh injection and bounded write starvation.
module sdram_port_arbiter #(
  parameter int BurstLengthSDRAM  = 8,
  parameter int AddressWidthSDRAM = 24,
  parameter int RefreshInterval   = 780,
  parameter int StarveLimit       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_port_arbiter_if.slave  bus
);
  localparam int RW = $clog2(RefreshInterval);
  localparam int SW = $clog2(StarveLimit + 1);
  localparam logic [RW-1:0] RELOAD = RW'(RefreshInterval - 1);
  localparam logic [SW-1:0] SLIM   = SW'(StarveLimit);

  if (BurstLengthSDRAM < 1 || RefreshInterval < 2 || StarveLimit < 1) begin : g_bad_param
    $error("sdram_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, REF, WR, RD} state_t;

  state_t                       state, state_n;
  logic                         wr_grant, wr_grant_n;
  logic                         rd_grant, rd_grant_n;
  logic                         enable, enable_n;
  logic                         read, read_n;
  logic                         refresh, refresh_n;
  logic [AddressWidthSDRAM-1:0] addr, addr_n;
  logic [SW-1:0]                starve, starve_n;
  logic [RW-1:0]                ref_cnt;
  logic                         ref_pending;
  logic                         overrun;
  logic                         ref_issue;
  logic                         expire;

  assign expire = (ref_cnt == '0);

  always_comb begin
    state_n    = state;
    wr_grant_n = wr_grant;
    rd_grant_n = rd_grant;
    enable_n   = 1'b0;
    refresh_n  = 1'b0;
    read_n     = read;
    addr_n     = addr;
    starve_n   = starve;
    ref_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.sdram_busy) begin
          if (ref_pending) begin
            state_n   = REF;
            refresh_n = 1'b1;
            ref_issue = 1'b1;
          end else if (bus.wr_req && (starve == SLIM || !bus.rd_req)) begin
            state_n    = WR;
            enable_n   = 1'b1;
            read_n     = 1'b0;
            addr_n     = bus.wr_addr;
            wr_grant_n = 1'b1;
            starve_n   = '0;
          end else if (bus.rd_req) begin
            state_n    = RD;
            enable_n   = 1'b1;
            read_n     = 1'b1;
            addr_n     = bus.rd_addr;
            rd_grant_n = 1'b1;
            if (!bus.wr_req)
              starve_n = '0;
            else if (starve != SLIM)
              starve_n = starve + 1'b1;
          end
        end
      end
      REF: begin
        if (bus.sdram_done)
          state_n = IDLE;
      end
      WR, RD: begin
        if (bus.sdram_done) begin
          state_n    = IDLE;
          wr_grant_n = 1'b0;
          rd_grant_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_grant <= 1'b0;
      rd_grant <= 1'b0;
      enable   <= 1'b0;
      read     <= 1'b0;
      refresh  <= 1'b0;
      addr     <= '0;
      starve   <= '0;
    end else begin
      state    <= state_n;
      wr_grant <= wr_grant_n;
      rd_grant <= rd_grant_n;
      enable   <= enable_n;
      read     <= read_n;
      refresh  <= refresh_n;
      addr     <= addr_n;
      starve   <= starve_n;
    end
  end

  // An expiry coinciding with the refresh strobe re-arms pending without counting as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt     <= RELOAD;
      ref_pending <= 1'b0;
      overrun     <= 1'b0;
    end else if (expire) begin
      ref_cnt     <= RELOAD;
      ref_pending <= 1'b1;
      if (ref_pending && !ref_issue)
        overrun <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt - 1'b1;
      if (ref_issue)
        ref_pending <= 1'b0;
    end
  end

  assign bus.wr_grant        = wr_grant;
  assign bus.rd_grant        = rd_grant;
  assign bus.sdram_enable    = enable;
  assign bus.sdram_read      = read;
  assign bus.sdram_refresh   = refresh;
  assign bus.sdram_addr      = addr;
  assign bus.refresh_overrun = overrun;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level
// reference model; the bench also plays the SDRAM engine (busy/done).
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int RI = 10;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.AddressWidthSDRAM(AW)) bus ();

  sdram_port_arbiter #(
    .BurstLengthSDRAM (8),
    .AddressWidthSDRAM(AW),
    .RefreshInterval  (RI),
    .StarveLimit      (SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycle count since reset release, refresh debt, outstanding command.
  int          k;
  int          pend;
  int          streak;
  int          busy_cmd;     // 0 none, 1 refresh, 2 write, 3 read
  logic        e_enable, e_refresh, e_read, e_wrg, e_rdg, e_ovr;
  logic [AW-1:0] e_addr;

  task automatic model_reset();
    k = 0; pend = 0; streak = 0; busy_cmd = 0;
    e_enable = 0; e_refresh = 0; e_read = 0; e_wrg = 0; e_rdg = 0; e_ovr = 0; e_addr = '0;
  endtask

  task automatic model_update();
    bit served;
    served = 0;
    k++;
    e_enable  = 0;
    e_refresh = 0;
    if (busy_cmd == 0) begin
      if (!bus.sdram_busy) begin
        if (pend > 0) begin
          busy_cmd = 1; e_refresh = 1; served = 1;
        end else if (bus.wr_req && (streak == SL || !bus.rd_req)) begin
          busy_cmd = 2; e_enable = 1; e_read = 0; e_addr = bus.wr_addr; e_wrg = 1; streak = 0;
        end else if (bus.rd_req) begin
          busy_cmd = 3; e_enable = 1; e_read = 1; e_addr = bus.rd_addr; e_rdg = 1;
          streak = bus.wr_req ? ((streak < SL) ? streak + 1 : SL) : 0;
        end
      end
    end else if (bus.sdram_done) begin
      busy_cmd = 0; e_wrg = 0; e_rdg = 0;
    end
    if (k % RI == 0) begin
      if (pend > 0 && !served) e_ovr = 1;
      pend = 1;
    end else if (served) begin
      pend = 0;
    end
  endtask

  task automatic compare();
    check("wr_grant", bus.wr_grant, e_wrg);
    check("rd_grant", bus.rd_grant, e_rdg);
    check("enable", bus.sdram_enable, e_enable);
    check("refresh", bus.sdram_refresh, e_refresh);
    check("read", bus.sdram_read, e_read);
    check("addr", bus.sdram_addr, e_addr);
    check("overrun", bus.refresh_overrun, e_ovr);
  endtask

  // SDRAM engine stand-in.
  bit eng_active, hold_done, noise, rand_len;
  int eng_rem, fixed_len, ref_len;

  function automatic int pick_len(input bit is_ref);
    if (is_ref && ref_len != 0) return ref_len;
    return rand_len ? int'($urandom_range(1, 8)) : fixed_len;
  endfunction

  task automatic engine_drive();
    if (bus.sdram_enable || bus.sdram_refresh) begin
      eng_active     = 1;
      eng_rem        = pick_len(bus.sdram_refresh) - 1;
      bus.sdram_busy = 1;
      bus.sdram_done = (eng_rem == 0) && !hold_done;
    end else if (eng_active) begin
      if (bus.sdram_done) begin
        eng_active = 0; bus.sdram_done = 0; bus.sdram_busy = 0;
      end else if (eng_rem == 0) begin
        bus.sdram_done = !hold_done;
      end else begin
        eng_rem--;
        if (eng_rem == 0 && !hold_done) bus.sdram_done = 1;
      end
    end else begin
      bus.sdram_busy = noise && ($urandom % 4 == 0);
      bus.sdram_done = noise && ($urandom % 8 == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    engine_drive();
  endtask

  task automatic do_reset();
    rst = 1;
    bus.wr_req = 0; bus.rd_req = 0; bus.wr_addr = '0; bus.rd_addr = '0;
    bus.sdram_busy = 0; bus.sdram_done = 0;
    eng_active = 0; hold_done = 0; noise = 0; rand_len = 0; fixed_len = 3; ref_len = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare();
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int ref_k[8];
  int n_ref, n_en, gcnt, ng, ncmd;
  int cmds[3];
  int exp_rd[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    // Idle: periodic refresh only.
    do_reset();
    n_ref = 0; n_en = 0;
    for (int c = 0; c < 45; c++) begin
      step();
      if (bus.sdram_refresh && n_ref < 8) begin ref_k[n_ref] = k; n_ref++; end
      if (bus.sdram_enable) n_en++;
    end
    check("ref_count", n_ref, 4);
    check("ref_first", ref_k[0], 11);
    check("ref_period1", ref_k[1] - ref_k[0], RI);
    check("ref_period2", ref_k[2] - ref_k[1], RI);
    check("idle_enables", n_en, 0);
    check("idle_overrun", bus.refresh_overrun, 0);

    // Single write burst of 8.
    do_reset();
    fixed_len = 8; bus.wr_req = 1; bus.wr_addr = 24'h000040;
    gcnt = 0; n_en = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.sdram_enable) begin
        n_en++;
        check("wr_addr", bus.sdram_addr, 24'h000040);
        check("wr_read", bus.sdram_read, 0);
        bus.wr_req = 0;
      end
      if (bus.wr_grant) gcnt++;
      else if (gcnt > 0) break;
    end
    check("wr_len", gcnt, 8);
    check("wr_enables", n_en, 1);

    // Starvation bound with both requests held.
    do_reset();
    fixed_len = 2; bus.wr_req = 1; bus.rd_req = 1;
    bus.wr_addr = 24'(($urandom)); bus.rd_addr = 24'(($urandom));
    ng = 0;
    for (int c = 0; c < 400 && ng < 10; c++) begin
      step();
      if (bus.sdram_enable) begin
        check("order", bus.sdram_read, exp_rd[ng]);
        ng++;
        bus.wr_addr = 24'(($urandom)); bus.rd_addr = 24'(($urandom));
      end
    end
    check("order_n", ng, 10);

    // Refresh expiring during a read burst is served right after it.
    do_reset();
    fixed_len = 9; ref_len = 2; bus.wr_req = 1; bus.rd_req = 1;
    ncmd = 0;
    for (int c = 0; c < 60 && ncmd < 3; c++) begin
      step();
      if (bus.sdram_refresh) begin cmds[ncmd] = 0; ncmd++; end
      else if (bus.sdram_enable) begin cmds[ncmd] = bus.sdram_read ? 1 : 2; ncmd++; end
    end
    check("rfd_n", ncmd, 3);
    check("rfd_cmd0", cmds[0], 1);
    check("rfd_cmd1", cmds[1], 0);
    check("rfd_cmd2", cmds[2], 1);

    // Done withheld: overrun sets and sticks.
    do_reset();
    hold_done = 1;
    repeat (35) step();
    check("ovr_set", bus.refresh_overrun, 1);
    repeat (15) step();
    check("ovr_sticky", bus.refresh_overrun, 1);

    // Asynchronous reset in the middle of a write grant.
    do_reset();
    fixed_len = 8; bus.wr_req = 1; bus.wr_addr = 24'h0ABCDE;
    gcnt = 0;
    for (int c = 0; c < 20 && gcnt == 0; c++) begin
      step();
      if (bus.wr_grant) gcnt = 1;
    end
    check("pre_rst_grant", gcnt, 1);
    #2 rst = 1;
    #1;
    check("async_wr_grant", bus.wr_grant, 0);
    check("async_enable", bus.sdram_enable, 0);
    check("async_addr", bus.sdram_addr, 0);
    do_reset();
    n_ref = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.sdram_refresh && n_ref < 8) begin ref_k[n_ref] = k; n_ref++; end
    end
    check("post_rst_ref", ref_k[0], 11);

    // Randomized traffic.
    do_reset();
    noise = 1; rand_len = 1;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (bus.wr_grant) bus.wr_req = 0;
      else if (!bus.wr_req && ($urandom % 3 == 0)) begin
        bus.wr_req = 1; bus.wr_addr = 24'(($urandom));
      end
      if (bus.rd_grant) bus.rd_req = 0;
      else if (!bus.rd_req && ($urandom % 2 == 0)) begin
        bus.rd_req = 1; bus.rd_addr = 24'(($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
